// File: rtl/alu_result_wb.sv
// Writeback stage after the ALU: two-entry result FIFO plus the architectural NZCV register.
// Define COND_EVAL_EN to squash results whose 4-bit condition code fails against NZCV.
module alu_result_wb #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_fz,
  input  logic              in_fc,
  input  logic              in_fn,
  input  logic              in_fv,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_set_flags,
  input  logic [3:0]        in_cond,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [3:0]        flags_nzcv,
  output logic [1:0]        occupancy
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [RD_W-1:0]   rd_q [2];
  logic [RD_W-1:0]   rd_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic [3:0]        nzcv_q, nzcv_d;

  logic pass;
  logic accept;
  logic push;
  logic pop;

`ifdef COND_EVAL_EN
  // Condition is judged against NZCV as it stands before this result's own update.
  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = nzcv_q;
    pass = 1'b0;
    unique case (in_cond)
      4'd0:  pass = z;
      4'd1:  pass = !z;
      4'd2:  pass = c;
      4'd3:  pass = !c;
      4'd4:  pass = n;
      4'd5:  pass = !n;
      4'd6:  pass = v;
      4'd7:  pass = !v;
      4'd8:  pass = c && !z;
      4'd9:  pass = !c || z;
      4'd10: pass = (n == v);
      4'd11: pass = (n != v);
      4'd12: pass = !z && (n == v);
      4'd13: pass = z || (n != v);
      4'd14: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end
`else
  logic unused_cond;
  assign unused_cond = ^in_cond;
  assign pass        = 1'b1;
`endif

  assign in_ready  = rst_n && (count_q != 2'd2);
  assign out_valid = rst_n && (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && pass;
  assign pop       = out_valid && out_ready;

  assign out_data   = (count_q != 2'd0) ? data_q[rd_ptr_q] : '0;
  assign out_rd     = (count_q != 2'd0) ? rd_q[rd_ptr_q]   : '0;
  assign flags_nzcv = nzcv_q;
  assign occupancy  = count_q;

  always_comb begin
    data_d   = data_q;
    rd_d     = rd_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    nzcv_d   = nzcv_q;

    if (push) begin
      data_d[wr_ptr_q] = in_result;
      rd_d[wr_ptr_q]   = in_rd;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    // Flags commit at accept time, independent of when the entry drains.
    if (push && in_set_flags) begin
      nzcv_d = {in_fn, in_fz, in_fc, in_fv};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q[0] <= '0;
      data_q[1] <= '0;
      rd_q[0]   <= '0;
      rd_q[1]   <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      nzcv_q    <= 4'b0000;
    end else begin
      data_q[0] <= data_d[0];
      data_q[1] <= data_d[1];
      rd_q[0]   <= rd_d[0];
      rd_q[1]   <= rd_d[1];
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      nzcv_q    <= nzcv_d;
    end
  end

endmodule
